// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch/decode constants and the fetch entry type
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side enqueue, decode-side dequeue and control bundle
interface fetch_queue_if #(
  parameter int XLEN  = pipeline_pkg::XLEN,
  parameter int DEPTH = 4
);
  logic                       stall;
  logic                       flush;
  logic                       enq_valid;
  logic                       enq_ready;
  logic [XLEN-1:0]            enq_pc;
  logic [31:0]                enq_inst;
  logic                       deq_valid;
  logic [XLEN-1:0]            deq_pc;
  logic [31:0]                deq_inst;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output stall, flush, enq_valid, enq_pc, enq_inst,
    input  enq_ready, deq_valid, deq_pc, deq_inst, count
  );
  modport slave (
    input  stall, flush, enq_valid, enq_pc, enq_inst,
    output enq_ready, deq_valid, deq_pc, deq_inst, count
  );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: pointers, occupancy count and handshake fire logic (FETCHQ_BYPASS_EN enables empty-queue bypass)
module fetch_queue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       enq_ready,
  output logic                       enq_fire,
  output logic                       bypass,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  logic deq_fire;
  // a bypassed instruction is consumed directly, so it must not also be written
  always_comb begin
    enq_ready = count != CW'(DEPTH);
`ifdef FETCHQ_BYPASS_EN
    bypass = (count == '0) & enq_valid & ~stall & ~flush;
`else
    bypass = 1'b0;
`endif
    enq_fire = enq_valid & enq_ready & ~flush & ~bypass;
    deq_fire = (count != '0) & ~stall & ~flush;
  end
  // flush clears everything and overrides any same-cycle traffic
  always_ff @(posedge clk or posedge reset)
    if (reset | flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{($clog2(DEPTH)-1){1'b0}}, enq_fire};
      rd_ptr <= rd_ptr + {{($clog2(DEPTH)-1){1'b0}}, deq_fire};
      count  <= count + CW'(enq_fire) - CW'(deq_fire);
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {pc, inst} fetch buffer with NOP bubble when empty (FETCHQ_BYPASS_EN enables 0-cycle bypass)
module fetch_queue #(
  parameter int          XLEN     = pipeline_pkg::XLEN,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = pipeline_pkg::NOP_INST
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave q
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;
  entry_t                     mem [DEPTH];
  logic [$clog2(DEPTH)-1:0]   wr_ptr, rd_ptr;
  logic                       enq_fire, bypass;
  fetch_queue_ctrl #(.DEPTH(DEPTH)) ctrl (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (q.enq_valid),
    .stall     (q.stall),
    .flush     (q.flush),
    .enq_ready (q.enq_ready),
    .enq_fire  (enq_fire),
    .bypass    (bypass),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (q.count)
  );
  // storage has no reset; validity comes from count
  always_ff @(posedge clk)
    if (enq_fire) mem[wr_ptr] <= '{pc: q.enq_pc, inst: q.enq_inst};
  // head entry, bypassed fetch data, or the NOP bubble
  always_comb begin
    q.deq_valid = bypass | (q.count != '0);
    q.deq_pc    = bypass ? q.enq_pc : (q.count != '0) ? mem[rd_ptr].pc : '0;
    q.deq_inst  = bypass ? q.enq_inst : (q.count != '0) ? mem[rd_ptr].inst : NOP_INST;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based model
module tb_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t mq[$];
  fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();
  fetch_queue #(.XLEN(32), .DEPTH(4), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask
  function automatic bit mbyp();
`ifdef FETCHQ_BYPASS_EN
    return mq.size() == 0 && bus.enq_valid && !bus.stall && !bus.flush;
`else
    return 1'b0;
`endif
  endfunction
  task automatic cmp_model();
    bit b = mbyp();
    int n = mq.size();
    chk("m_count", 64'(bus.count), 64'(n));
    chk("m_enq_ready", 64'(bus.enq_ready), 64'(n != 4));
    chk("m_deq_valid", 64'(bus.deq_valid), 64'(n != 0 || b));
    chk("m_deq_pc", 64'(bus.deq_pc), n != 0 ? 64'(mq[0].pc) : b ? 64'(bus.enq_pc) : 64'd0);
    chk("m_deq_inst", 64'(bus.deq_inst), n != 0 ? 64'(mq[0].inst) : b ? 64'(bus.enq_inst) : 64'(NOP));
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic st, input logic fl);
    bus.enq_valid = v;
    bus.enq_pc = pc;
    bus.enq_inst = inst;
    bus.stall = st;
    bus.flush = fl;
    @(negedge clk);
    cmp_model();
  endtask
  task automatic tick();
    bit b;
    int n;
    @(posedge clk);
    b = mbyp();
    n = mq.size();
    if (bus.flush) mq.delete();
    else begin
      if (n != 0 && !bus.stall) void'(mq.pop_front());
      if (bus.enq_valid && n < 4 && !b) mq.push_back('{bus.enq_pc, bus.enq_inst});
    end
    #1;
  endtask
  initial begin
    bus.enq_valid = 0; bus.enq_pc = 0; bus.enq_inst = 0; bus.stall = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("rst_count", 64'(bus.count), 0);
    chk("rst_valid", 64'(bus.deq_valid), 0);
    chk("rst_inst", 64'(bus.deq_inst), 64'h13);
    chk("rst_ready", 64'(bus.enq_ready), 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 32'(32'hA000 + i), 1, 0);
      tick();
    end
    drive(1, 32'h10, 32'hBEEF, 1, 0);
    chk("full_count", 64'(bus.count), 4);
    chk("full_ready", 64'(bus.enq_ready), 0);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("full_hold_count", 64'(bus.count), 4);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("drain_pc", 64'(bus.deq_pc), 64'(i * 4));
      chk("drain_inst", 64'(bus.deq_inst), 64'(32'hA000 + i));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("drain_empty_valid", 64'(bus.deq_valid), 0);
    chk("drain_empty_inst", 64'(bus.deq_inst), 64'h13);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'(k * 4), 32'(32'hC000 + k), 0, 0);
`ifdef FETCHQ_BYPASS_EN
      chk("stream_pc", 64'(bus.deq_pc), 64'(k * 4));
      chk("stream_count", 64'(bus.count), 0);
`else
      if (k > 0) begin
        chk("stream_pc", 64'(bus.deq_pc), 64'((k - 1) * 4));
        chk("stream_count", 64'(bus.count), 1);
      end
`endif
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(32'h20 + i * 4), 32'(32'hD000 + i), 1, 0);
      tick();
    end
    drive(1, 32'h2C, 32'hD003, 0, 1);
    chk("preflush_count", 64'(bus.count), 3);
    chk("preflush_pc", 64'(bus.deq_pc), 64'h20);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("flush_count", 64'(bus.count), 0);
    chk("flush_inst", 64'(bus.deq_inst), 64'h13);
    tick();
    drive(1, 32'h100, 32'hE000, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("postflush_pc", 64'(bus.deq_pc), 64'h100);
    tick();
    drive(1, 32'h40, 32'hF040, 0, 0);
`ifdef FETCHQ_BYPASS_EN
    chk("byp_valid", 64'(bus.deq_valid), 1);
    chk("byp_pc", 64'(bus.deq_pc), 64'h40);
    chk("byp_count", 64'(bus.count), 0);
    tick();
`else
    chk("nobyp_valid", 64'(bus.deq_valid), 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("nobyp_pc", 64'(bus.deq_pc), 64'h40);
    tick();
`endif
    drive(0, 0, 0, 1, 0);
    chk("stall_empty_inst", 64'(bus.deq_inst), 64'h13);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'(32'h80 + i * 4), 32'h1234, 1, 0);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", 64'(bus.count), 0);
    chk("async_rst_valid", 64'(bus.deq_valid), 0);
    chk("async_rst_pc", 64'(bus.deq_pc), 0);
    mq.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(9) < 7, $urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(9) < 3, $urandom_range(19) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction fetch buffer. It is the multi-entry successor to the single fetch/decode pipeline register and sits between instruction memory and decode.
- Decouples fetch from decode using a DEPTH-entry FIFO of {pc, inst} pairs with valid/ready handshake on the enqueue side.
- Drains one entry per cycle unless decode stalls.
- Discards all buffered instructions on a taken branch and presents a NOP bubble to decode whenever empty.

Parameters:
XLEN, 32, width of pc field
DEPTH, 4, number of entries; power of two, >= 2
NOP_INST, 32'h0000_0013, instruction presented to decode when no valid entry (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  decode cannot accept; head entry held
flush  input  1  branch taken in execute; discard all entries
enq_valid  input  1  fetch presents pc/inst
enq_ready  output  1  queue can accept this cycle
enq_pc  input  XLEN  pc of fetched instruction
enq_inst  input  32  fetched instruction
deq_valid  output  1  head entry valid for decode
deq_pc  output  XLEN  head pc; 0 when deq_valid=0
deq_inst  output  32  head instruction; NOP_INST when deq_valid=0
count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (async, reset=1): wr_ptr=rd_ptr=0, count=0. Outputs: deq_valid=0, deq_pc=0, deq_inst=NOP_INST, enq_ready=1. Storage contents are don't-care.
- Handshake signals:
  - enq_fire = enq_valid & enq_ready & ~flush.
  - deq_fire = deq_valid & ~stall & ~flush.
- enq_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from stall.
- Enqueue: on enq_fire, {enq_pc, enq_inst} is written at wr_ptr and wr_ptr advances. The entry becomes visible at the head the next cycle, so baseline latency is 1 cycle.
- Dequeue: deq_valid = (count != 0). deq_pc and deq_inst are read combinationally from rd_ptr. rd_ptr advances on deq_fire.
- Count update: enq_fire only -> +1; deq_fire only -> -1; both or neither -> unchanged. Full with enq_valid=1 is not accepted; fetch must hold pc.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. Full/empty are derived from count, not from pointer equality.
- Flush: at the next edge wr_ptr=rd_ptr=0 and count=0. Flush overrides a same-cycle enqueue and dequeue; the fetched instruction is dropped. The cycle after flush shows deq_valid=0 and deq_inst=NOP_INST.
- Stall with empty queue: no effect; the NOP bubble continues.
- Stall and flush together: flush wins.
- Reset asserted mid-operation: state clears immediately, with no dependence on clk.

Optional Feature:
FETCHQ_BYPASS_EN
- Defined: when count==0, enq_valid=1, stall=0 and flush=0, the enqueue data drives deq_pc/deq_inst combinationally and deq_valid=1. The entry is consumed the same cycle without being written, so count and pointers are unchanged (0-cycle latency).
- Not defined: empty-queue latency is always 1 cycle.
- enq_ready is identical in both builds.

Decomposition:
- Package pipeline_pkg holds:
  - localparam NOP_INST;
  - typedef fetch_entry_t as a packed struct {logic [XLEN-1:0] pc; logic [31:0] inst}, with XLEN as a package parameter defaulting to 32.
- One natural sub-module: fetch_queue_ctrl, holding the pointers, count and fire logic. The top keeps the storage array and output muxing.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then release -> count=0, deq_valid=0, deq_inst=32'h00000013, enq_ready=1.
- Fill to full with stall=1: enqueue pc 0x0,0x4,0x8,0xC (DEPTH=4) -> count=4 and enq_ready=0. A fifth enq_valid with pc 0x10 is not accepted and count stays 4.
- Drain in order: release stall from full -> deq_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles, then deq_valid=0 with NOP.
- Simultaneous enq/deq wrap: stream 10 sequential pcs from 0x0 with stall=0 -> count stays at 1 after the first cycle, pointers wrap twice, output order is preserved.
- Flush with traffic: count=3 holding pcs 0x20,0x24,0x28, plus enq pc 0x2C and flush=1 in the same cycle -> next cycle count=0 and deq_inst=NOP. Enqueuing pc 0x100 then appears as the head one cycle later.
- Bypass (FETCHQ_BYPASS_EN defined): empty queue, enq pc 0x40 with stall=0 -> same cycle deq_valid=1 and deq_pc=0x40; count stays 0. Undefined build: deq_pc=0x40 appears one cycle later.
